// File: rtl/cam_capture_rgb332_if.sv
// rtl/cam_capture_rgb332_if.sv - camera input pins and frame-buffer write port of the RGB332 capture block
interface cam_capture_rgb332_if #(
    parameter int AW = 17,
    parameter int DW = 8
);
    logic          CAM_pclk;
    logic          CAM_href;
    logic          CAM_vsync;
    logic [7:0]    CAM_px_data;
    logic [AW-1:0] DP_RAM_addr_in;
    logic [DW-1:0] DP_RAM_data_in;
    logic          DP_RAM_regW;
    logic          frame_done;
    logic          overflow;

    // capture block: samples the camera, drives the buffer write port
    modport master (
        input  CAM_pclk, CAM_href, CAM_vsync, CAM_px_data,
        output DP_RAM_addr_in, DP_RAM_data_in, DP_RAM_regW, frame_done, overflow
    );

    // camera model / buffer side
    modport slave (
        output CAM_pclk, CAM_href, CAM_vsync, CAM_px_data,
        input  DP_RAM_addr_in, DP_RAM_data_in, DP_RAM_regW, frame_done, overflow
    );
endinterface

// File: rtl/cam_capture_rgb332.sv
// rtl/cam_capture_rgb332.sv - OV7670 RGB565 capture, converted to RGB332 and written to the frame buffer
module cam_capture_rgb332 #(
    parameter int CAM_SCREEN_X = 320,
    parameter int CAM_SCREEN_Y = 240,
    parameter int AW           = 17,
    parameter int DW           = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    cam_capture_rgb332_if.master  bus
);
    localparam logic [AW-1:0] PIX_TOTAL = AW'(CAM_SCREEN_X * CAM_SCREEN_Y);

    localparam logic [1:0] WAIT_VS_HIGH = 2'd0;
    localparam logic [1:0] WAIT_VS_LOW  = 2'd1;
    localparam logic [1:0] BYTE1        = 2'd2;
    localparam logic [1:0] BYTE2        = 2'd3;

    // two-flop synchronisers plus a third flop on the edge-detected lines
    logic       pclk_s1, pclk_s2, pclk_s3;
    logic       href_s1, href_s2;
    logic       vsync_s1, vsync_s2, vsync_s3;
    logic [7:0] data_s1, data_s2;

    // decision stage: edges and the *_s2 values they belong to, held together
    logic       pclk_rise_q, href_q, vsync_q, vsync_rise_q, vsync_fall_q;
    logic [7:0] data_q;

    logic          pclk_rise, vsync_rise, vsync_fall;
    logic [1:0]    state;
    logic [AW-1:0] pix_cnt;
    logic [2:0]    r_q, g_hi_q;
    logic [DW-1:0] px_next;

    assign pclk_rise  = pclk_s2 & ~pclk_s3;
    assign vsync_rise = vsync_s2 & ~vsync_s3;
    assign vsync_fall = ~vsync_s2 & vsync_s3;

    // RGB332 = R[4:2], G[5:3], B[4:3] of the RGB565 pixel
    assign px_next = DW'({r_q, g_hi_q, data_q[4:3]});

    // bring the asynchronous camera signals into the clk domain
    always_ff @(posedge clk) begin
        if (rst) begin
            pclk_s1  <= 1'b0; pclk_s2  <= 1'b0; pclk_s3  <= 1'b0;
            href_s1  <= 1'b0; href_s2  <= 1'b0;
            vsync_s1 <= 1'b0; vsync_s2 <= 1'b0; vsync_s3 <= 1'b0;
            data_s1  <= 8'd0; data_s2  <= 8'd0;
        end else begin
            pclk_s1  <= bus.CAM_pclk;    pclk_s2  <= pclk_s1;  pclk_s3  <= pclk_s2;
            href_s1  <= bus.CAM_href;    href_s2  <= href_s1;
            vsync_s1 <= bus.CAM_vsync;   vsync_s2 <= vsync_s1; vsync_s3 <= vsync_s2;
            data_s1  <= bus.CAM_px_data; data_s2  <= data_s1;
        end
    end

    // register the edge pulses together with the sampled line/frame/data values
    always_ff @(posedge clk) begin
        if (rst) begin
            pclk_rise_q  <= 1'b0;
            href_q       <= 1'b0;
            vsync_q      <= 1'b0;
            vsync_rise_q <= 1'b0;
            vsync_fall_q <= 1'b0;
            data_q       <= 8'd0;
        end else begin
            pclk_rise_q  <= pclk_rise;
            href_q       <= href_s2;
            vsync_q      <= vsync_s2;
            vsync_rise_q <= vsync_rise;
            vsync_fall_q <= vsync_fall;
            data_q       <= data_s2;
        end
    end

    // frame/byte sequencing, pixel assembly and buffer write strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= WAIT_VS_HIGH;
            pix_cnt            <= '0;
            r_q                <= 3'd0;
            g_hi_q             <= 3'd0;
            bus.DP_RAM_addr_in <= '0;
            bus.DP_RAM_data_in <= '0;
            bus.DP_RAM_regW    <= 1'b0;
            bus.frame_done     <= 1'b0;
            bus.overflow       <= 1'b0;
        end else begin
            bus.DP_RAM_regW <= 1'b0;
            bus.frame_done  <= 1'b0;
            case (state)
                // vsync must be seen high first so the first frame is never partial
                WAIT_VS_HIGH: begin
                    if (vsync_q) state <= WAIT_VS_LOW;
                end
                WAIT_VS_LOW: begin
                    if (vsync_fall_q) begin
                        state        <= BYTE1;
                        pix_cnt      <= '0;
                        bus.overflow <= 1'b0;
                    end
                end
                BYTE1, BYTE2: begin
                    if (vsync_rise_q) begin
                        // end of frame wins over a coincident pixel edge
                        bus.frame_done <= 1'b1;
                        state          <= WAIT_VS_LOW;
                    end else if (!href_q) begin
                        // line gap: drop any half pixel so lines start on a high byte
                        state <= BYTE1;
                    end else if (pclk_rise_q) begin
                        if (state == BYTE1) begin
                            r_q    <= data_q[7:5];
                            g_hi_q <= data_q[2:0];
                            state  <= BYTE2;
                        end else begin
                            state <= BYTE1;
                            if (pix_cnt == PIX_TOTAL) begin
                                bus.overflow <= 1'b1;
                            end else begin
                                bus.DP_RAM_data_in <= px_next;
                                bus.DP_RAM_addr_in <= pix_cnt;
                                bus.DP_RAM_regW    <= 1'b1;
                                pix_cnt            <= pix_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: state <= WAIT_VS_HIGH;
            endcase
        end
    end
endmodule
